// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for the per-set pseudo-LRU bank.
package plru_pkg;

  typedef enum logic {
    PLRU_HIT  = 1'b0,
    PLRU_MISS = 1'b1
  } plru_op_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WALK = 2'd2,
    ST_RESP = 2'd3
  } plru_state_e;

  function automatic int parent(input int i);
    return (i - 1) >> 1;
  endfunction

  function automatic int left_child(input int i);
    return 2 * i + 1;
  endfunction

  function automatic logic is_left(input int i);
    return i[0];
  endfunction

endpackage

// File: rtl/plru_tree_step.sv
// One tree-walk step: descend from an internal node (flipping it) or climb from
// a node to its parent (pointing the parent away from where we came from).
module plru_tree_step
  import plru_pkg::*;
#(
  parameter int WAYS     = 8,
  parameter int IDX_BITS = $clog2(WAYS) + 1
) (
  input  logic [IDX_BITS-1:0] i_node,
  input  logic [WAYS-2:0]     i_tree,
  input  logic                i_descend,
  output logic [IDX_BITS-1:0] o_node,
  output logic [WAYS-2:0]     o_tree
);

  localparam int NODES = WAYS - 1;

  logic [IDX_BITS-1:0] w_parent;
  logic [NODES-1:0]    w_here;
  logic                w_cur_bit;
  logic                w_away;

  assign w_parent  = IDX_BITS'(parent(int'(i_node)));
  // A left child makes its parent point right (1), a right child points it left (0).
  assign w_away    = is_left(int'(i_node));
  assign w_cur_bit = |(w_here & i_tree);
  assign o_node    = i_descend ? IDX_BITS'(left_child(int'(i_node)) + int'(w_cur_bit))
                               : w_parent;

  genvar gi;
  generate
    for (gi = 0; gi < NODES; gi++) begin : g_node
      assign w_here[gi] = (i_node == IDX_BITS'(gi));
      assign o_tree[gi] = (i_descend && w_here[gi])                   ? ~i_tree[gi] :
                          (!i_descend && (w_parent == IDX_BITS'(gi))) ? w_away      :
                                                                        i_tree[gi];
    end
  endgenerate

endmodule

// File: rtl/plru_bank.sv
// Multi-set tree pseudo-LRU controller: per-set tree storage, HIT touch and
// MISS victim selection (invalid way first), walked one tree level per cycle.
module plru_bank
  import plru_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int WAYS     = 8,
  parameter int SET_BITS = $clog2(NUM_SETS),
  parameter int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [WAY_BITS-1:0] req_way,
  input  logic [WAYS-1:0]     req_vmask,
  output logic                rsp_valid,
  output logic [WAY_BITS-1:0] rsp_way,
  output logic                busy
);

  localparam int NODES    = WAYS - 1;
  localparam int IDX_BITS = WAY_BITS + 1;
  localparam int LVL_BITS = $clog2(WAY_BITS + 1);

  plru_state_e         r_state;
  logic [SET_BITS-1:0] r_init_set;
  logic [LVL_BITS-1:0] r_level;
  logic [SET_BITS-1:0] r_set;
  logic                r_descend;
  logic [IDX_BITS-1:0] r_node;
  logic [NODES-1:0]    r_tree;
  logic [WAY_BITS-1:0] r_victim;
  logic                r_rsp_valid;
  logic [WAY_BITS-1:0] r_rsp_way;
  logic [NODES-1:0]    r_mem [NUM_SETS];

  logic                w_miss;
  logic                w_has_free;
  logic [WAY_BITS-1:0] w_free_way;
  logic [WAY_BITS-1:0] w_start_way;
  logic                w_start_desc;
  logic [IDX_BITS-1:0] w_step_node;
  logic [NODES-1:0]    w_step_tree;
  logic [WAY_BITS-1:0] w_leaf_way;
  logic                w_mem_we;
  logic [SET_BITS-1:0] w_mem_waddr;
  logic [NODES-1:0]    w_mem_wdata;

  always_comb begin
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (!req_vmask[k]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_BITS'(k);
      end
    end
  end

  assign w_miss       = (req_op == PLRU_MISS);
  // Only a full-valid miss consults the tree; otherwise the way is known up front.
  assign w_start_desc = w_miss && !w_has_free;
  assign w_start_way  = w_miss ? w_free_way : req_way;
  assign w_leaf_way   = WAY_BITS'(w_step_node - IDX_BITS'(WAYS - 1));

  plru_tree_step #(
    .WAYS     (WAYS),
    .IDX_BITS (IDX_BITS)
  ) u_step (
    .i_node    (r_node),
    .i_tree    (r_tree),
    .i_descend (r_descend),
    .o_node    (w_step_node),
    .o_tree    (w_step_tree)
  );

  assign w_mem_we    = !rst && ((r_state == ST_INIT) || (r_state == ST_RESP));
  assign w_mem_waddr = (r_state == ST_INIT) ? r_init_set : r_set;
  assign w_mem_wdata = (r_state == ST_INIT) ? '0 : r_tree;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_set  <= '0;
      r_level     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_way   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_init_set <= r_init_set + SET_BITS'(1);
          if (r_init_set == SET_BITS'(NUM_SETS - 1)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            r_set     <= req_set;
            r_tree    <= r_mem[req_set];
            r_descend <= w_start_desc;
            r_victim  <= w_start_way;
            r_node    <= w_start_desc ? '0 : ({1'b0, w_start_way} + IDX_BITS'(WAYS - 1));
            r_level   <= '0;
            r_state   <= ST_WALK;
          end
        end
        ST_WALK: begin
          r_tree  <= w_step_tree;
          r_node  <= w_step_node;
          r_level <= r_level + LVL_BITS'(1);
          if (r_level == LVL_BITS'(WAY_BITS - 1)) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_way   <= r_descend ? w_leaf_way : r_victim;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_way   = r_rsp_way;

endmodule

// File: tb/tb_plru_bank.sv
// Directed bench for plru_bank: a 4-set/4-way instance for the main sequences
// and a 4-set/8-way instance for the mid-walk reset case.
module tb_plru_bank;
  import plru_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       a_rst, a_req_valid, a_req_ready, a_req_op, a_rsp_valid, a_busy;
  logic [1:0] a_req_set, a_req_way, a_rsp_way;
  logic [3:0] a_req_vmask;

  logic       b_rst, b_req_valid, b_req_ready, b_req_op, b_rsp_valid, b_busy;
  logic [1:0] b_req_set;
  logic [2:0] b_req_way, b_rsp_way;
  logic [7:0] b_req_vmask;

  plru_bank #(.NUM_SETS(4), .WAYS(4)) u_dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_op(a_req_op), .req_set(a_req_set), .req_way(a_req_way),
    .req_vmask(a_req_vmask), .rsp_valid(a_rsp_valid), .rsp_way(a_rsp_way),
    .busy(a_busy)
  );

  plru_bank #(.NUM_SETS(4), .WAYS(8)) u_dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(b_req_op), .req_set(b_req_set), .req_way(b_req_way),
    .req_vmask(b_req_vmask), .rsp_valid(b_rsp_valid), .rsp_way(b_rsp_way),
    .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request on instance A; checks ready, walk state, latency, result and hold.
  task automatic a_xact(input string tag, input logic op, input logic [1:0] set,
                        input logic [1:0] way, input logic [3:0] vm, input logic [1:0] exp_way);
    int wait_n = 0;
    int lat    = 1;
    while (!a_req_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq({tag, "_ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1; a_req_op = op; a_req_set = set; a_req_way = way; a_req_vmask = vm;
    @(negedge clk);
    a_req_valid = 1'b0; a_req_op = ~op; a_req_set = ~set; a_req_way = ~way; a_req_vmask = ~vm;
    check_eq({tag, "_walk_ready"}, 32'(a_req_ready), 32'd0);
    while (!a_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd3);
    check_eq({tag, "_way"}, 32'(a_rsp_way), 32'(exp_way));
    $display("xact A %s op=%0d set=%0d way=%0d vmask=%b -> rsp_way=%0d lat=%0d",
             tag, op, set, way, vm, a_rsp_way, lat);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(a_rsp_valid), 32'd0);
    check_eq({tag, "_hold"}, 32'(a_rsp_way), 32'(exp_way));
  endtask

  task automatic b_xact(input string tag, input logic [1:0] set, input logic [2:0] exp_way);
    int wait_n = 0;
    int lat    = 1;
    while (!b_req_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq({tag, "_ready"}, 32'(b_req_ready), 32'd1);
    b_req_valid = 1'b1; b_req_op = PLRU_MISS; b_req_set = set; b_req_vmask = 8'hFF;
    @(negedge clk);
    b_req_valid = 1'b0;
    while (!b_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq({tag, "_way"}, 32'(b_rsp_way), 32'(exp_way));
    $display("xact B %s MISS set=%0d vmask=ff -> rsp_way=%0d lat=%0d", tag, set, b_rsp_way, lat);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    int n;
    a_rst = 1'b1; a_req_valid = 1'b0; a_req_op = PLRU_HIT; a_req_set = '0; a_req_way = '0; a_req_vmask = '0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_op = PLRU_HIT; b_req_set = '0; b_req_way = '0; b_req_vmask = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(a_req_ready), 32'd0);
    check_eq("rst_busy", 32'(a_busy), 32'd1);
    check_eq("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("rst_rsp_way", 32'(a_rsp_way), 32'd0);

    // Release reset with a request already waiting; it must not be taken during INIT.
    a_rst = 1'b0;
    a_req_valid = 1'b1; a_req_op = PLRU_MISS; a_req_set = 2'd3; a_req_vmask = 4'hF;
    check_eq("init_c1_ready", 32'(a_req_ready), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("init_c%0d_ready", c), 32'(a_req_ready), 32'd0);
      check_eq($sformatf("init_c%0d_rsp", c), 32'(a_rsp_valid), 32'd0);
    end
    @(negedge clk);
    check_eq("init_c5_ready", 32'(a_req_ready), 32'd1);
    check_eq("init_c5_busy", 32'(a_busy), 32'd0);

    a_xact("miss_s3_0", PLRU_MISS, 2'd3, 2'd0, 4'hF, 2'd0);
    a_xact("miss_s3_1", PLRU_MISS, 2'd3, 2'd0, 4'hF, 2'd2);
    a_xact("miss_s3_2", PLRU_MISS, 2'd3, 2'd0, 4'hF, 2'd1);
    a_xact("miss_s3_3", PLRU_MISS, 2'd3, 2'd0, 4'hF, 2'd3);

    a_xact("hit_s1_w0", PLRU_HIT, 2'd1, 2'd0, 4'h0, 2'd0);
    a_xact("miss_s1", PLRU_MISS, 2'd1, 2'd3, 4'hF, 2'd2);

    a_xact("miss_s2_inv", PLRU_MISS, 2'd2, 2'd0, 4'b1011, 2'd2);
    a_xact("miss_s2_full", PLRU_MISS, 2'd2, 2'd0, 4'hF, 2'd0);

    a_xact("miss_s0_iso", PLRU_MISS, 2'd0, 2'd0, 4'hF, 2'd0);
    a_xact("miss_s0_next", PLRU_MISS, 2'd0, 2'd0, 4'hF, 2'd2);

    // Instance B: one miss to dirty set 1, then reset in the middle of a second walk.
    @(negedge clk);
    b_rst = 1'b0;
    b_xact("b_miss_s1_0", 2'd1, 3'd0);
    b_req_valid = 1'b1; b_req_op = PLRU_MISS; b_req_set = 2'd1; b_req_vmask = 8'hFF;
    @(negedge clk);
    b_req_valid = 1'b0;
    check_eq("b_midwalk_busy", 32'(b_busy), 32'd1);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    seen = 0;
    n = 0;
    while (!b_req_ready && n < 50) begin
      if (b_rsp_valid) seen++;
      @(negedge clk);
      n++;
    end
    check_eq("b_reset_no_rsp", 32'(seen), 32'd0);
    check_eq("b_reinit_cycles", 32'(n), 32'd4);
    $display("xact B midwalk_reset -> rsp_seen=%0d reinit_cycles=%0d", seen, n);
    b_xact("b_miss_s1_after", 2'd1, 3'd0);
    b_xact("b_miss_s1_next", 2'd1, 3'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
